instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port imem_req  output  1  instruction memory read request.
REQ-005 SHALL provide port imem_addr  output  32  word-aligned read address.
REQ-006 SHALL provide port imem_ack  input  1  memory response valid; may be asserted in the same cycle as imem_req.
REQ-007 SHALL provide port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL provide port instr_valid  output  1  instr/pc hold a valid instruction for decode.
REQ-009 SHALL provide port instr_ready  input  1  decode accepts the instruction this cycle.
REQ-010 SHALL provide port instr  output  32  registered instruction word.
REQ-011 SHALL provide port opcode  output  6  instr[31:26], combinational.
REQ-012 SHALL provide port funct  output  6  instr[5:0], combinational.
REQ-013 SHALL provide port pc  output  32  address of the instruction in instr.
REQ-014 SHALL provide port pc_plus4  output  32  pc+4 mod 2^32, combinational.
REQ-015 SHALL provide port redirect  input  1  branch/jump/jr taken; flush and refetch.
REQ-016 SHALL provide port redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).

Function
REQ-017 SHALL implement states FETCH, HOLD, DRAIN; internal registers fetch_pc and pend_pc.
REQ-018 SHALL, in FETCH, drive imem_req=1 and imem_addr=fetch_pc; in HOLD drive imem_req=0; in DRAIN drive imem_req=1 with imem_addr held at the outstanding address.
REQ-019 SHALL keep imem_req and imem_addr stable from assertion until the cycle imem_ack=1 (memory contract, including across redirects).
REQ-020 SHALL, in FETCH with imem_ack=1 and redirect=0: instr<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, instr_valid<=1, go HOLD.
REQ-021 SHALL, in HOLD with instr_ready=1 and redirect=0: instr_valid<=0, go FETCH; with instr_ready=0 hold instr, pc, instr_valid unchanged.
REQ-022 SHALL give redirect priority over all other events in every state.
REQ-023 SHALL, on redirect in HOLD: instr_valid<=0 (squash, regardless of instr_ready), fetch_pc<=redirect_pc, go FETCH.
REQ-024 SHALL, on redirect in FETCH with imem_ack=1: discard imem_rdata, instr_valid stays 0, fetch_pc<=redirect_pc, stay FETCH.
REQ-025 SHALL, on redirect in FETCH with imem_ack=0: pend_pc<=redirect_pc, go DRAIN.
REQ-026 SHALL, in DRAIN: on imem_ack=1 discard data, fetch_pc<=(redirect ? redirect_pc : pend_pc), go FETCH; on imem_ack=0 with redirect, pend_pc<=redirect_pc (latest wins).
REQ-027 SHALL never assert instr_valid in FETCH or DRAIN.
REQ-028 SHALL wrap fetch_pc and pc_plus4 modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-029 SHALL achieve minimum latency of 1 cycle from imem_ack to instr_valid, and max throughput of one instruction per 2 cycles.

Reset
REQ-030 SHALL, while reset=1, force state=FETCH, fetch_pc=RESET_PC, pend_pc=0, instr=0, pc=RESET_PC, instr_valid=0, imem_req=0; reset overrides redirect and imem_ack.
REQ-031 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-032 SHALL discard any memory response outstanding when reset is asserted mid-fetch.

Verification
REQ-033 SHALL cover: reset release, imem_ack same cycle, instr_ready=1 -> addresses 0x0,0x4,0x8 fetched, instr_valid high every 2nd cycle, pc matches.
REQ-034 SHALL cover: instr_ready=0 for 5 cycles in HOLD -> instr/pc stable, imem_req=0, then accept -> next fetch 0x4.
REQ-035 SHALL cover: redirect to 0x100 in HOLD with instr_ready=1 -> instr squashed, next imem_addr=0x100.
REQ-036 SHALL cover: imem_ack delayed 3 cycles, redirect to 0x200 then 0x300 before ack -> old addr held, data dropped, next imem_addr=0x300.
REQ-037 SHALL cover: redirect to 0x203 with simultaneous imem_ack -> data dropped, next imem_addr=0x200.
REQ-038 SHALL cover: RESET_PC=32'hFFFF_FFFC -> pc_plus4=0, second fetch address 0x0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads to instruction memory and hands one
// registered instruction at a time to decode, with redirect (branch/jump) support.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [31:0] redirect_tgt;
    logic        unused_redirect_lsbs;

    // Redirect targets are forced word-aligned; the dropped bits are intentionally unused.
    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= 32'h0000_0000;
            instr_q    <= 32'h0000_0000;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        case (state_q)
            FETCH: begin
                valid_d = 1'b0;
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_d = redirect_tgt;
                    end else begin
                        instr_d    = imem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    // Request is already on the bus; park the target until it completes.
                    pend_pc_d = redirect_tgt;
                    state_d   = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = redirect_tgt;
                    state_d    = FETCH;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                if (imem_ack) begin
                    fetch_pc_d = redirect ? redirect_tgt : pend_pc_q;
                    state_d    = FETCH;
                end else if (redirect) begin
                    pend_pc_d = redirect_tgt;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    // The outstanding address lives in fetch_pc for both FETCH and DRAIN.
    assign imem_req    = !reset && (state_q != HOLD);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, decode stall, redirects in
// HOLD/FETCH/DRAIN and a second instance with a wrapping reset address.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        auto_ack, man_ack;

    logic        w_req, w_ack, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc_plus4;
    logic [5:0]  w_opcode, w_funct;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory returns a recognisable word: opcode 0x2B with the address in the low bits.
    always_comb begin
        imem_ack   = auto_ack ? imem_req : man_ack;
        imem_rdata = 32'hAC00_0000 + imem_addr;
        w_ack      = w_req;
        w_rdata    = 32'hAC00_0000 + w_addr;
    end

    instr_fetch u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .instr_valid (w_valid),
        .instr_ready (1'b1),
        .instr       (w_instr),
        .opcode      (w_opcode),
        .funct       (w_funct),
        .pc          (w_pc),
        .pc_plus4    (w_pc_plus4),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        auto_ack    = 1'b1;
        man_ack     = 1'b0;

        // Reset state
        repeat (3) tick();
        check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_instr", instr, 32'h0);
        check_val("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        check_val("wrap_rst_pc_plus4", w_pc_plus4, 32'h0);

        // Sequential fetch with same-cycle ack and decode always ready
        reset = 1'b0;
        #1;
        check_val("rel_req", {31'd0, imem_req}, 32'd1);
        check_val("rel_addr", imem_addr, 32'h0);
        check_val("wrap_rel_addr", w_addr, 32'hFFFF_FFFC);
        tick();
        check_val("seq0_valid", {31'd0, instr_valid}, 32'd1);
        check_val("seq0_pc", pc, 32'h0);
        check_val("seq0_instr", instr, 32'hAC00_0000);
        check_val("seq0_opcode", {26'd0, opcode}, 32'h2B);
        check_val("seq0_pc_plus4", pc_plus4, 32'h4);
        check_val("seq0_req", {31'd0, imem_req}, 32'd0);
        check_val("wrap_valid", {31'd0, w_valid}, 32'd1);
        check_val("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check_val("wrap_pc_plus4", w_pc_plus4, 32'h0);
        tick();
        check_val("seq1_valid", {31'd0, instr_valid}, 32'd0);
        check_val("seq1_addr", imem_addr, 32'h4);
        check_val("wrap_next_addr", w_addr, 32'h0);
        tick();
        check_val("seq1b_valid", {31'd0, instr_valid}, 32'd1);
        check_val("seq1b_pc", pc, 32'h4);
        check_val("seq1b_funct", {26'd0, funct}, 32'h4);
        tick();
        check_val("seq2_addr", imem_addr, 32'h8);
        tick();
        check_val("seq2b_pc", pc, 32'h8);
        check_val("seq2b_instr", instr, 32'hAC00_0008);

        // Reset overrides redirect; then stall decode for 5 cycles
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        instr_ready = 1'b0;
        repeat (2) tick();
        reset    = 1'b0;
        redirect = 1'b0;
        #1;
        check_val("rst2_addr", imem_addr, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("stall%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            check_val($sformatf("stall%0d_pc", i), pc, 32'h0);
            check_val($sformatf("stall%0d_instr", i), instr, 32'hAC00_0000);
            check_val($sformatf("stall%0d_req", i), {31'd0, imem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check_val("accept_addr", imem_addr, 32'h4);
        check_val("accept_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_val("accept_pc", pc, 32'h4);

        // Redirect in HOLD with decode ready: squash and refetch at 0x100
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        check_val("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        check_val("hold_redir_addr", imem_addr, 32'h100);
        redirect = 1'b0;
        tick();
        check_val("hold_redir_pc", pc, 32'h100);
        check_val("hold_redir_instr", instr, 32'hAC00_0100);

        // Slow memory: two redirects while 0x104 is outstanding
        auto_ack = 1'b0;
        tick();
        check_val("slow_addr0", imem_addr, 32'h104);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        check_val("drain_addr1", imem_addr, 32'h104);
        check_val("drain_req1", {31'd0, imem_req}, 32'd1);
        redirect_pc = 32'h300;
        tick();
        check_val("drain_addr2", imem_addr, 32'h104);
        check_val("drain_valid2", {31'd0, instr_valid}, 32'd0);
        redirect = 1'b0;
        man_ack  = 1'b1;
        tick();
        check_val("drain_done_valid", {31'd0, instr_valid}, 32'd0);
        check_val("drain_done_addr", imem_addr, 32'h300);
        man_ack  = 1'b0;
        auto_ack = 1'b1;
        tick();
        check_val("drain_fetch_pc", pc, 32'h300);
        check_val("drain_fetch_valid", {31'd0, instr_valid}, 32'd1);

        // Misaligned redirect coinciding with ack in FETCH
        tick();
        check_val("ack_redir_addr0", imem_addr, 32'h304);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        tick();
        check_val("ack_redir_valid", {31'd0, instr_valid}, 32'd0);
        check_val("ack_redir_addr", imem_addr, 32'h200);
        redirect = 1'b0;
        tick();
        check_val("ack_redir_pc", pc, 32'h200);
        check_val("ack_redir_instr", instr, 32'hAC00_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
